// File: rtl/pipe_adder_stage.sv
// Combinational CW-bit ripple-carry adder: a chain of 1-bit full adders, no state.
module pipe_adder_stage #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    for (genvar i = 0; i < CW; i++) begin : g_fa
        logic w_ci;
        logic w_co;

        if (i == 0) begin : g_cin
            assign w_ci = cin;
        end else begin : g_cin
            assign w_ci = g_fa[i-1].w_co;
        end

        assign s[i] = x[i] ^ y[i] ^ w_ci;
        assign w_co = (x[i] & y[i]) | (w_ci & (x[i] ^ y[i]));
    end

    assign cout = g_fa[CW-1].w_co;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple slice per stage, with a
// valid/ready handshake where every stage advances together or holds.
module pipe_adder #(
    parameter int WIDTH  = 13,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

    logic w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Trailing stages can end up with no bits when CHUNK rounds up; they only delay.
        localparam int LO  = (k * CHUNK < WIDTH) ? k * CHUNK : WIDTH;
        localparam int TOP = (LO + CHUNK < WIDTH) ? LO + CHUNK : WIDTH;
        localparam int CW  = TOP - LO;

        logic           r_v;
        logic           r_c;
        logic [TOP-1:0] r_s;
        logic           w_nv;
        logic           w_nc;
        logic [TOP-1:0] w_ns;

        if (k == 0) begin : g_add
            pipe_adder_stage #(.CW(CW)) u_stage (
                .x    (a[TOP-1:LO]),
                .y    (b[TOP-1:LO] ^ {CW{sub}}),
                .cin  (sub),
                .s    (w_ns),
                .cout (w_nc)
            );
            assign w_nv = in_valid;
        end else if (CW > 0) begin : g_add
            logic [CW-1:0] w_chunk;

            pipe_adder_stage #(.CW(CW)) u_stage (
                .x    (g_st[k-1].g_op.r_a[TOP-1:LO]),
                .y    (g_st[k-1].g_op.r_b[TOP-1:LO] ^ {CW{g_st[k-1].g_op.r_sub}}),
                .cin  (g_st[k-1].r_c),
                .s    (w_chunk),
                .cout (w_nc)
            );
            assign w_ns = {w_chunk, g_st[k-1].r_s};
            assign w_nv = g_st[k-1].r_v;
        end else begin : g_add
            assign w_ns = g_st[k-1].r_s;
            assign w_nc = g_st[k-1].r_c;
            assign w_nv = g_st[k-1].r_v;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_nv;
                r_c <= w_nc;
                r_s <= w_ns;
            end
        end

        // Operand bits above this stage's slice, still waiting for a later stage.
        if (TOP < WIDTH) begin : g_op
            logic [WIDTH-1:TOP] r_a;
            logic [WIDTH-1:TOP] r_b;
            logic               r_sub;
            logic [WIDTH-1:TOP] w_na;
            logic [WIDTH-1:TOP] w_nb;
            logic               w_nsub;

            if (k == 0) begin : g_src
                assign w_na   = a[WIDTH-1:TOP];
                assign w_nb   = b[WIDTH-1:TOP];
                assign w_nsub = sub;
            end else begin : g_src
                assign w_na   = g_st[k-1].g_op.r_a[WIDTH-1:TOP];
                assign w_nb   = g_st[k-1].g_op.r_b[WIDTH-1:TOP];
                assign w_nsub = g_st[k-1].g_op.r_sub;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sub <= 1'b0;
                end else if (w_adv) begin
                    r_a   <= w_na;
                    r_b   <= w_nb;
                    r_sub <= w_nsub;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = {g_st[STAGES-1].r_c, g_st[STAGES-1].r_s};

endmodule
